// File: rtl/emulate_pull_ctrl_pkg.sv
// Shared phase-window helpers and pull level constants for emulate_pull_ctrl.
// Pure definitions; no logic, latency or backpressure of its own.
package emulate_pull_ctrl_pkg;

   localparam logic PULL_DOWN = 1'b0;
   localparam logic PULL_UP   = 1'b1;

   // Phase counter width; never narrower than one bit.
   function automatic int phase_w(input int period);
      return (period > 1) ? $clog2(period) : 1;
   endfunction

   function automatic int min_period(input int drive_cycles, input int settle_cycles);
      return drive_cycles + settle_cycles + 1;
   endfunction

   function automatic logic in_drive(input int phase, input int drive_cycles);
      return phase < drive_cycles;
   endfunction

   function automatic logic in_settle(input int phase, input int drive_cycles,
                                      input int settle_cycles);
      return (phase >= drive_cycles) && (phase < drive_cycles + settle_cycles);
   endfunction

   function automatic logic pull_level(input logic up);
      return up ? PULL_UP : PULL_DOWN;
   endfunction

endpackage

// File: rtl/pull_glitch_filter.sv
// Per-channel de-glitch: level changes only after DEPTH consecutive differing strobed samples.
// Built only with EMULATE_PULL_FILTER_EN; level updates the clock after a qualifying strobe; no backpressure.
`ifdef EMULATE_PULL_FILTER_EN
module pull_glitch_filter
   import emulate_pull_ctrl_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   input  logic raw,
   output logic level
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         level <= PULL_DOWN;
      end else if (strobe) begin
         if (raw == level) begin
            cnt <= '0;
         end else if (cnt >= CNT_LAST) begin
            level <= raw;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule
`endif

// File: rtl/emulate_pull_ctrl.sv
// Emulated per-pin pull-up/down: drive in the DRIVE window, tristate to settle, sample once at phase PERIOD-1.
// out lags the sample edge by 1 clk (EMULATE_PULL_FILTER_EN: FILTER_DEPTH periods); free-running, no backpressure.
module emulate_pull_ctrl
   import emulate_pull_ctrl_pkg::*;
#(
   parameter int WIDTH         = 1,
   parameter int PERIOD        = 16,
   parameter int DRIVE_CYCLES  = 1,
   parameter int SETTLE_CYCLES = 2,
   parameter int FILTER_DEPTH  = 3
) (
   input  logic             clk,
   input  logic             rst,
   inout  wire  [WIDTH-1:0] pin,
   input  logic [WIDTH-1:0] pull_up,
   input  logic [WIDTH-1:0] pull_en,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] changed,
   output logic             sample_strobe
);

   localparam int PW = phase_w(PERIOD);
   localparam logic [PW-1:0] PHASE_LAST = PW'(PERIOD - 1);
   localparam logic [PW-1:0] PHASE_PRE  = PW'(PERIOD - 2);

   if (PERIOD < min_period(DRIVE_CYCLES, SETTLE_CYCLES) || FILTER_DEPTH < 1) begin : g_bad_cfg
      $error("emulate_pull_ctrl: PERIOD must be >= DRIVE_CYCLES+SETTLE_CYCLES+1 and FILTER_DEPTH >= 1");
   end

   logic [PW-1:0]    phase;
   logic [WIDTH-1:0] cfg_up;
   logic [WIDTH-1:0] cfg_en;
   logic [WIDTH-1:0] raw;
   logic             raw_vld;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_prev;
   logic             drive_win;

   // Reset gates the drivers combinationally so pins release in the same cycle rst rises.
   assign drive_win = !rst && in_drive(int'(phase), DRIVE_CYCLES);

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign pin[i] = (drive_win && cfg_en[i]) ? pull_level(cfg_up[i]) : 1'bz;
   end

   // cfg loads on the edge entering phase 0, so the whole DRIVE window sees one stable setting.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase         <= '0;
         cfg_up        <= pull_up;
         cfg_en        <= pull_en;
         sample_strobe <= 1'b0;
         raw           <= '0;
         raw_vld       <= 1'b0;
         out_prev      <= '0;
         changed       <= '0;
      end else begin
         phase         <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
         sample_strobe <= (phase == PHASE_PRE);
         raw_vld       <= sample_strobe;
         out_prev      <= out_q;
         changed       <= out_q ^ out_prev;
         if (phase == PHASE_LAST) begin
            cfg_up <= pull_up;
            cfg_en <= pull_en;
         end
         if (sample_strobe) begin
            raw <= pin;
         end
      end
   end

`ifdef EMULATE_PULL_FILTER_EN
   for (genvar i = 0; i < WIDTH; i++) begin : g_filt
      pull_glitch_filter #(
         .DEPTH (FILTER_DEPTH)
      ) u_filt (
         .clk    (clk),
         .rst    (rst),
         .strobe (raw_vld),
         .raw    (raw[i]),
         .level  (out_q[i])
      );
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
      end else if (raw_vld) begin
         out_q <= raw;
      end
   end
`endif

   assign out = out_q;

endmodule

// File: tb/tb_emulate_pull_ctrl.sv
// Bench for emulate_pull_ctrl: pins modelled as floating wires that hold the last driven level.
module tb_emulate_pull_ctrl;

   localparam int W = 4;
   localparam int P = 16;
`ifdef EMULATE_PULL_FILTER_EN
   localparam int NPER = 3;
   localparam bit FILT = 1'b1;
`else
   localparam int NPER = 1;
   localparam bit FILT = 1'b0;
`endif
   // Cycles from the start of the first period whose sample differs to the changed pulse.
   localparam int LAT = (NPER - 1) * P + 18;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] pull_up = 4'b0101;
   logic [W-1:0] pull_en = 4'hF;
   wire  [W-1:0] pin;
   logic [W-1:0] out;
   logic [W-1:0] changed;
   logic         sample_strobe;

   logic [W-1:0] ext_en  = '0;
   logic [W-1:0] ext_val = '0;
   logic [W-1:0] keeper  = '0;
   logic [W-1:0] kv      = '0;
   logic [W-1:0] exp_up  = '0;
   logic [W-1:0] exp_en  = '0;
   int tb_phase = 0;
   int gcyc     = 0;
   int checks   = 0;
   int failures = 0;

   typedef struct {
      int           cyc;
      logic [W-1:0] chg;
      logic [W-1:0] outv;
   } ev_t;
   ev_t q[$];

   always #5 clk = ~clk;

   emulate_pull_ctrl #(
      .WIDTH(W), .PERIOD(P), .DRIVE_CYCLES(1), .SETTLE_CYCLES(2), .FILTER_DEPTH(3)
   ) dut (
      .clk(clk), .rst(rst), .pin(pin), .pull_up(pull_up), .pull_en(pull_en),
      .out(out), .changed(changed), .sample_strobe(sample_strobe)
   );

   // Environment: external force wins; otherwise the wire holds its last level except while the DUT should drive.
   for (genvar i = 0; i < W; i++) begin : g_env
      assign pin[i] = ext_en[i] ? ext_val[i] :
                      ((kv[i] && !(tb_phase == 0 && !rst && exp_en[i])) ? keeper[i] : 1'bz);
   end

   always @(posedge clk) begin
      gcyc <= gcyc + 1;
      tb_phase <= rst ? 0 : ((tb_phase == P - 1) ? 0 : tb_phase + 1);
      if (rst || tb_phase == P - 1) begin
         exp_up <= pull_up;
         exp_en <= pull_en;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < W; i++) begin
         if (ext_en[i]) begin
            keeper[i] <= ext_val[i];
            kv[i]     <= 1'b1;
         end else if (!rst && tb_phase == 0 && exp_en[i]) begin
            keeper[i] <= pin[i];
            kv[i]     <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, gcyc, act, req);
      end
   endtask

   // Monitor: pin levels, strobe timing, and changed events against the scoreboard.
   always @(negedge clk) begin
      ev_t e;
      chk("sample_strobe", 32'(sample_strobe), 32'(tb_phase == P - 1));
      if (!rst) begin
         for (int i = 0; i < W; i++) begin
            if (ext_en[i]) begin
               if (!(tb_phase == 0 && exp_en[i]))
                  chk($sformatf("pin%0d_forced", i), 32'(pin[i]), 32'(ext_val[i]));
            end else if (tb_phase == 0 && exp_en[i]) begin
               chk($sformatf("pin%0d_drive", i), 32'(pin[i]), 32'(exp_up[i]));
            end
         end
      end
      if (changed != '0) begin
         if (q.size() == 0) begin
            chk("unexpected_changed", 32'(changed), 32'd0);
         end else begin
            e = q.pop_front();
            chk("event_cycle", 32'(gcyc), 32'(e.cyc));
            chk("event_changed", 32'(changed), 32'(e.chg));
            chk("event_out", 32'(out), 32'(e.outv));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_phase(input int p);
      int n = 0;
      tick();
      while (tb_phase != p && n < 64) begin
         tick();
         n++;
      end
   endtask

   task automatic push(input int cyc, input logic [W-1:0] chg, input logic [W-1:0] outv);
      ev_t e;
      e.cyc  = cyc;
      e.chg  = chg;
      e.outv = outv;
      q.push_back(e);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (q.size() != 0 && n < 400) begin
         tick();
         n++;
      end
      chk(name, 32'(q.size()), 32'd0);
      repeat (2) tick();
   endtask

   initial begin
      int s;
      int n;
      // Reset state.
      repeat (3) tick();
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_changed", 32'(changed), 32'd0);
      chk("rst_strobe", 32'(sample_strobe), 32'd0);

      // 1: floating pins settle to their pull levels.
      rst = 1'b0;
      s = gcyc;
      push(s + LAT, 4'b0101, 4'b0101);
      drain("t1_events");
      repeat (2 * P) tick();

      // 2: external drive overrides a pull-down, then release.
      wait_phase(2);
      s = gcyc - 2;
      ext_val[1] = 1'b1;
      ext_en[1]  = 1'b1;
      push(s + LAT, 4'b0010, 4'b0111);
      drain("t2_force");
      wait_phase(2);
      s = gcyc - 2;
      ext_en[1] = 1'b0;
      push(s + P + LAT, 4'b0010, 4'b0101);
      drain("t2_release");

      // 3a: one-period glitch on pull-down pin 3.
      wait_phase(10);
      s = gcyc - 10;
      ext_val[3] = 1'b1;
      ext_en[3]  = 1'b1;
      if (!FILT) begin
         push(s + LAT, 4'b1000, 4'b1101);
         push(s + P + LAT, 4'b1000, 4'b0101);
      end
      wait_phase(0);
      ext_en[3] = 1'b0;
      drain("t3_glitch");
      repeat (2 * P) tick();

      // 3b: three-period hold on pin 3.
      wait_phase(10);
      s = gcyc - 10;
      ext_en[3] = 1'b1;
      push(s + LAT, 4'b1000, 4'b1101);
      push(s + 3 * P + LAT, 4'b1000, 4'b0101);
      repeat (3) wait_phase(0);
      ext_en[3] = 1'b0;
      drain("t3_hold");

      // 4: mid-period pull_up change takes effect from the next DRIVE window.
      wait_phase(5);
      s = gcyc - 5;
      pull_up[0] = 1'b0;
      push(s + P + LAT, 4'b0001, 4'b0100);
      drain("t4_events");

      // 5: disabled channel is never driven; forced low it reads low.
      wait_phase(5);
      s = gcyc - 5;
      pull_en[2] = 1'b0;
      wait_phase(5);
      ext_val[2] = 1'b0;
      ext_en[2]  = 1'b1;
      push(s + P + LAT, 4'b0100, 4'b0000);
      drain("t5_events");
      repeat (P) tick();
      wait_phase(5);
      s = gcyc - 5;
      ext_en[2]  = 1'b0;
      pull_en[2] = 1'b1;
      pull_up[0] = 1'b1;
      push(s + P + LAT, 4'b0101, 4'b0101);
      drain("t5_restore");

      // 6: reset mid-period for two cycles.
      wait_phase(8);
      rst = 1'b1;
      tick();
      chk("rst6_out", 32'(out), 32'd0);
      chk("rst6_changed", 32'(changed), 32'd0);
      tick();
      chk("rst6_out_hold", 32'(out), 32'd0);
      rst = 1'b0;
      s = gcyc;
      push(s + LAT, 4'b0101, 4'b0101);
      n = 0;
      while (!sample_strobe && n < 40) begin
         tick();
         n++;
      end
      chk("rst6_strobe_delay", 32'(n), 32'd15);
      drain("t6_events");

      repeat (2 * P) tick();
      chk("final_out", 32'(out), 32'(4'b0101));
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
